res_port_arbiter: RTL and testbench
===================================

# res_port_arbiter

Two-requester arbiter for the single-port 16384×8 result memory used by the distance-transform engine. Port 0 serves the DT engine and port 1 serves the host readback/preload path. The arbiter multiplexes both onto one registered memory port and returns read data to the issuing requester with a fixed latency. Fairness is round-robin, with a bounded burst length and an optional lock that keeps ownership through a raster pass.

## Interface
- AW, 14, memory address width (16384 pixels)
- DW, 8, data width (distance value)
- MAX_BURST, 16, transfers one owner may make before yielding to a waiting requester (1..255)

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- req0 / req1  in  1  requester wants a transfer this cycle
- we0 / we1  in  1  1 = write, 0 = read (valid with req)
- addr0 / addr1  in  AW  transfer address
- wdata0 / wdata1  in  DW  write data
- lock0 / lock1  in  1  hold ownership regardless of burst count or own req
- gnt0 / gnt1  out  1  requester owns the port; transfer occurs when req&gnt
- rvalid0 / rvalid1  out  1  one-cycle pulse: read data returned
- rdata0 / rdata1  out  DW  read data, valid with rvalid
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_do  out  DW  memory write data
- mem_di  in  DW  memory read data, valid the cycle after mem_rd

## Operation
- States: IDLE, OWN0, OWN1. gnt0 = (state==OWN0), gnt1 = (state==OWN1); gnt is decoded from registered state only and never from req.
- IDLE: no grant. At the edge, one requester → its OWN state. Both requesting → the port indicated by rr_ptr (reset 0).
- OWNi, each edge:
  - req_i&gnt_i: transfer accepted; burst_cnt increments, saturating at MAX_BURST.
  - Stay in OWNi if lock_i=1.
  - Otherwise yield when req_i=0, or when burst_cnt reaches MAX_BURST with the other port requesting.
  - On yield: go to OWNother if the other port is requesting, else IDLE. Set rr_ptr = other and clear burst_cnt.
- Simultaneous lock0 and lock1: the current owner keeps the port. A lock from a non-owner has no effect until that port is granted.
- Accepted transfer: mem_rd = ~we, mem_wr = we, mem_addr/mem_do are the owner's inputs, all registered. mem_rd and mem_wr are never both 1.
- Read return: a 2-stage tag pipeline records the port of each read. rdata/rvalid of the tagged port are registered from mem_di. The other port's rvalid stays 0 and its rdata holds.
- Reads in flight complete to their original port even if ownership changes.

## Timing
- Reset values: state IDLE, rr_ptr 0, burst_cnt 0, gnt* 0, mem_rd/mem_wr 0, mem_addr 0, mem_do 0, rvalid* 0, rdata* 0.
- Grant latency: req rising in IDLE → gnt high the next cycle. Owner switch costs no idle cycle.
- Write: accepted at edge E0 → mem_wr high in cycle E0..E1.
- Read: accepted at E0 → mem_rd high E0..E1 → mem_di valid E1..E2 → rvalid high E2..E3. Latency is 2 edges, with a throughput of one transfer per cycle.
- Cycles without an accepted transfer drive mem_rd = mem_wr = 0. Address and data hold their last value.
- Asynchronous reset mid-burst: everything returns to reset values immediately. In-flight reads are dropped with no rvalid.

## Structure
- Package res_arb_pkg holds: state enum (IDLE, OWN0, OWN1), AW/DW defaults, port-index type.
- Sub-module res_arb_rtag: 2-deep read-tag shift register plus return-data register, producing rvalid*/rdata*.

## Test plan
- Single read: port0 reads addr 129, memory holds 8'd5 → gnt0 1 cycle after req, mem_rd/mem_addr=129 next cycle, rvalid0=1 with rdata0=5 two edges after acceptance; rvalid1 stays 0.
- Contention from reset: req0 and req1 both high continuously → port0 gets exactly 16 transfers, then port1 gets 16, alternating with no idle cycles between owners.
- Lock: port0 holds lock0=1 while deasserting req0 for 3 cycles, with req1 high → gnt0 stays 1 and gnt1 stays 0. After lock0 drops, port1 is granted the next cycle.
- Read return across a switch: port0 issues its final read to addr 16254 in the same cycle ownership passes to port1 → rvalid0 carries the data for 16254. Port1's first write shows mem_wr=1 the next cycle.
- Write then read same address: port1 writes 8'd7 to addr 300, then reads addr 300 → rdata1=7.
- Reset mid-burst: assert reset with a read in flight → all outputs go to 0 immediately, no rvalid pulse. After release, IDLE, and port0 wins a simultaneous request.

Source files
------------

// File: rtl/res_arb_pkg.sv
// Shared types for the result-memory port arbiter: FSM states, port index and width defaults.
package res_arb_pkg;
    localparam int AW_DEF = 14;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef logic port_t;
    localparam port_t PORT0 = 1'b0;
    localparam port_t PORT1 = 1'b1;
endpackage

// File: rtl/res_arb_rtag.sv
// Read-return path: remembers which port issued each read and steers mem_di back two edges later.
module res_arb_rtag
    import res_arb_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rd_issue,
    input  port_t         rd_port,
    input  logic [DW-1:0] mem_di,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1
);
    logic  tag_vld0, tag_vld1;
    port_t tag_port0, tag_port1;

    // Stage 0 lines up with mem_rd, stage 1 with mem_di; data is captured on the following edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_vld0  <= 1'b0;
            tag_vld1  <= 1'b0;
            tag_port0 <= PORT0;
            tag_port1 <= PORT0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            tag_vld0  <= rd_issue;
            tag_port0 <= rd_port;
            tag_vld1  <= tag_vld0;
            tag_port1 <= tag_port0;
            rvalid0   <= tag_vld1 && (tag_port1 == PORT0);
            rvalid1   <= tag_vld1 && (tag_port1 == PORT1);
            if (tag_vld1 && (tag_port1 == PORT0)) rdata0 <= mem_di;
            if (tag_vld1 && (tag_port1 == PORT1)) rdata1 <= mem_di;
        end
    end
endmodule

// File: rtl/res_port_arbiter.sv
// Round-robin arbiter multiplexing the DT engine (port 0) and host path (port 1) onto one registered memory port.
module res_port_arbiter
    import res_arb_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_do,
    input  logic [DW-1:0] mem_di
);
    localparam int CW = 8;

    arb_state_t    state;
    port_t         rr_ptr;
    logic [CW-1:0] burst_cnt;

    logic          acc0, acc1, acc, acc_we;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic [CW-1:0] cnt_inc;
    logic          at_limit;

    assign gnt0 = (state == OWN0);
    assign gnt1 = (state == OWN1);

    assign acc0      = req0 && gnt0;
    assign acc1      = req1 && gnt1;
    assign acc       = acc0 || acc1;
    assign acc_we    = acc1 ? we1 : we0;
    assign acc_addr  = acc1 ? addr1 : addr0;
    assign acc_wdata = acc1 ? wdata1 : wdata0;

    // The limit is judged on the count including this edge's transfer, so the owner gets exactly MAX_BURST.
    assign cnt_inc  = (acc && (burst_cnt != CW'(MAX_BURST))) ? burst_cnt + CW'(1) : burst_cnt;
    assign at_limit = (cnt_inc == CW'(MAX_BURST));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= PORT0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 && req1)  state <= (rr_ptr == PORT1) ? OWN1 : OWN0;
                    else if (req0)     state <= OWN0;
                    else if (req1)     state <= OWN1;
                end
                OWN0: begin
                    if (!lock0 && (!req0 || (at_limit && req1))) begin
                        state     <= req1 ? OWN1 : IDLE;
                        rr_ptr    <= PORT1;
                        burst_cnt <= '0;
                    end else begin
                        burst_cnt <= cnt_inc;
                    end
                end
                OWN1: begin
                    if (!lock1 && (!req1 || (at_limit && req0))) begin
                        state     <= req0 ? OWN0 : IDLE;
                        rr_ptr    <= PORT0;
                        burst_cnt <= '0;
                    end else begin
                        burst_cnt <= cnt_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address and data hold between transfers; only the strobes drop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            mem_do   <= '0;
        end else if (acc) begin
            mem_rd   <= !acc_we;
            mem_wr   <= acc_we;
            mem_addr <= acc_addr;
            mem_do   <= acc_wdata;
        end else begin
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
        end
    end

    res_arb_rtag #(.DW(DW)) u_rtag (
        .clk      (clk),
        .reset    (reset),
        .rd_issue (acc && !acc_we),
        .rd_port  (acc1 ? PORT1 : PORT0),
        .mem_di   (mem_di),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1)
    );
endmodule

// File: tb/tb_res_port_arbiter.sv
// Directed bench for res_port_arbiter with a behavioural 16384x8 memory and queue-based scoreboards.
module tb_res_port_arbiter;
    localparam int AW = 14;
    localparam int DW = 8;
    localparam int DEPTH = 16384;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic          lock0 = 1'b0, lock1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_rd, mem_wr;
    logic [DW-1:0] rdata0, rdata1, mem_do;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_di = '0;

    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] ref_mem [0:DEPTH-1];

    txn_t          mem_exp_q[$];
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    res_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(16)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_do(mem_do),
        .mem_di(mem_di)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 129) return 8'd5;
        return 8'(a) ^ 8'h5A;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] got);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0h with nothing expected", name, got);
    endtask

    // Synchronous memory: read data appears the cycle after mem_rd.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (mem_wr) mem[mem_addr] <= mem_do;
            if (mem_rd) mem_di <= mem[mem_addr];
        end
    end

    // Monitor: pops expectations whenever the DUT presents a memory strobe or a read return.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (mem_rd || mem_wr) begin
                    check("mem_strobe_excl", 32'(mem_rd && mem_wr), 32'd0);
                    if (mem_exp_q.size() == 0) begin
                        fail_now("mem_unexpected", 32'(mem_addr));
                    end else begin
                        txn_t t;
                        t = mem_exp_q.pop_front();
                        check("mem_we", 32'(mem_wr), 32'(t.we));
                        check("mem_addr", 32'(mem_addr), 32'(t.addr));
                        if (t.we) check("mem_do", 32'(mem_do), 32'(t.data));
                    end
                end
                if (rvalid0) begin
                    if (exp_q0.size() == 0) fail_now("rvalid0_unexpected", 32'(rdata0));
                    else check("rdata0", 32'(rdata0), 32'(exp_q0.pop_front()));
                end
                if (rvalid1) begin
                    if (exp_q1.size() == 0) fail_now("rvalid1_unexpected", 32'(rdata1));
                    else check("rdata1", 32'(rdata1), 32'(exp_q1.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit port);
        mem_exp_q.push_back({we, a, d});
        if (we) ref_mem[a] = d;
        else if (port) exp_q1.push_back(ref_mem[a]);
        else exp_q0.push_back(ref_mem[a]);
    endtask

    // Called after an edge with the inputs for the next edge already set.
    task automatic issue();
        if (req0 && gnt0) push(we0, addr0, wdata0, 1'b0);
        if (req1 && gnt1) push(we1, addr1, wdata1, 1'b1);
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b0;
        mem_exp_q.delete();
        exp_q0.delete();
        exp_q1.delete();
        repeat (3) tick();
        reset = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt0"}, 32'(gnt0), 32'd0);
        check({tag, "_gnt1"}, 32'(gnt1), 32'd0);
        check({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
        check({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_do"}, 32'(mem_do), 32'd0);
        check({tag, "_rvalid0"}, 32'(rvalid0), 32'd0);
        check({tag, "_rvalid1"}, 32'(rvalid1), 32'd0);
        check({tag, "_rdata0"}, 32'(rdata0), 32'd0);
        check({tag, "_rdata1"}, 32'(rdata1), 32'd0);
    endtask

    initial begin
        int  n, m;
        bit  g0, g1, wr_flag;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);

        // Reset values
        #1 reset = 1'b0;
        #1 check_all_zero("reset");
        apply_reset();

        // Single read of addr 129 by port 0
        req0 = 1; we0 = 0; addr0 = 14'd129;
        tick();
        check("single_gnt0", 32'(gnt0), 32'd1);
        check("single_gnt1", 32'(gnt1), 32'd0);
        issue();
        tick();
        req0 = 0;
        check("single_mem_rd", 32'(mem_rd), 32'd1);
        check("single_mem_addr", 32'(mem_addr), 32'd129);
        tick();
        check("single_rvalid0_early", 32'(rvalid0), 32'd0);
        tick();
        check("single_rvalid0", 32'(rvalid0), 32'd1);
        check("single_rdata0", 32'(rdata0), 32'd5);
        check("single_rvalid1", 32'(rvalid1), 32'd0);
        repeat (2) tick();

        // Contention from reset: 16-transfer bursts alternate with no idle cycle
        apply_reset();
        req0 = 1; we0 = 1; addr0 = 14'd1000; wdata0 = 8'hA0;
        req1 = 1; we1 = 1; addr1 = 14'd2000; wdata1 = 8'hB1;
        for (int k = 1; k <= 64; k++) begin
            bit exp0;
            tick();
            exp0 = (((k - 1) / 16) % 2) == 0;
            check("contend_gnt0", 32'(gnt0), 32'(exp0));
            check("contend_gnt1", 32'(gnt1), 32'(!exp0));
            if (k == 64) begin req0 = 0; req1 = 0; end
            issue();
        end
        repeat (3) tick();

        // Lock: port 0 keeps the port with req0 low; lock1 from the waiting port is ignored
        req0 = 1; we0 = 1; addr0 = 14'd50; wdata0 = 8'd11;
        tick();
        check("lock_gnt0_start", 32'(gnt0), 32'd1);
        req0 = 0; lock0 = 1; lock1 = 1;
        req1 = 1; we1 = 1; addr1 = 14'd60; wdata1 = 8'd22;
        issue();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("lock_gnt0_held", 32'(gnt0), 32'd1);
            check("lock_gnt1_held", 32'(gnt1), 32'd0);
            issue();
        end
        lock0 = 0; lock1 = 0;
        tick();
        check("lock_release_gnt1", 32'(gnt1), 32'd1);
        check("lock_release_gnt0", 32'(gnt0), 32'd0);
        issue();
        tick();
        req1 = 0;
        repeat (3) tick();

        // Read return across an owner switch, then port 1 writes 7 to 300 and reads it back
        n = 0; m = 0; wr_flag = 0;
        req0 = 1; we0 = 0; addr0 = 14'd16239;
        req1 = 1; we1 = 1; addr1 = 14'd300; wdata1 = 8'd7;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (wr_flag) begin
                check("switch_mem_wr", 32'(mem_wr), 32'd1);
                check("switch_mem_addr", 32'(mem_addr), 32'd300);
                wr_flag = 0;
            end
            if (n == 16) req0 = 0;
            addr0 = AW'(16239 + n);
            if (m == 1) we1 = 0;
            if (m >= 2) req1 = 0;
            g0 = req0 && gnt0;
            g1 = req1 && gnt1;
            if (g1 && m == 0) begin
                check("switch_port0_count", 32'(n), 32'd16);
                wr_flag = 1;
            end
            issue();
            if (g0) n++;
            if (g1) m++;
        end
        check("switch_last_addr0", 32'(addr0), 32'd16255);

        // Asynchronous reset with a read in flight
        req0 = 1; we0 = 0; addr0 = 14'd129;
        tick();
        tick();
        check("midrst_mem_rd_before", 32'(mem_rd), 32'd1);
        req0 = 0;
        #2 reset = 1'b0;
        #1 check_all_zero("midrst");
        for (int k = 0; k < 4; k++) begin
            tick();
            check("midrst_no_rvalid0", 32'(rvalid0), 32'd0);
        end
        reset = 1'b1;
        req0 = 1; we0 = 1; addr0 = 14'd10; wdata0 = 8'h33;
        req1 = 1; we1 = 1; addr1 = 14'd20; wdata1 = 8'h44;
        tick();
        check("postrst_gnt0", 32'(gnt0), 32'd1);
        check("postrst_gnt1", 32'(gnt1), 32'd0);
        issue();
        tick();
        req0 = 0; req1 = 0;
        repeat (6) tick();

        check("end_mem_q_empty", 32'(mem_exp_q.size()), 32'd0);
        check("end_rd0_q_empty", 32'(exp_q0.size()), 32'd0);
        check("end_rd1_q_empty", 32'(exp_q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
